instr_feeder: RTL and testbench

INSTR_FEEDER -- requirements
Module: instr_feeder

---
 rtl/instr_feeder.sv | 180 ++++++++++++++++++
 tb/tb_instr_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// Instruction feeder: steps through a small program memory and hands each word to a processor,
// with Run/Done handshaking, an mvi immediate fetch, a completion timeout and a halt marker.
`timescale 1ns / 1ps

module instr_feeder #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  localparam int unsigned PcWidth  = $clog2(DEPTH),
  localparam int unsigned TmWidth  = $clog2(TIMEOUT + 1)
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Start,
  input  logic               LoadEn,
  input  logic [PcWidth-1:0] LoadAddr,
  input  logic [15:0]        LoadData,
  input  logic               Done,
  input  logic [15:0]        BusWires,
  output logic [15:0]        DIN,
  output logic               Run,
  output logic [PcWidth-1:0] PC,
  output logic [15:0]        Result,
  output logic [7:0]         InstrCount,
  output logic               Busy,
  output logic               Finished,
  output logic               Error
);

  localparam int unsigned PcW1 = PcWidth + 1;
  localparam logic [PcWidth:0] LastPc = PcW1'(DEPTH - 1);
  localparam logic [TmWidth-1:0] TimeoutVal = TmWidth'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StHalt, StError} state_e;

  state_e state_q, state_d;

  logic [15:0] mem [DEPTH];

  // Extra MSB lets the counter step past the last word so the end of memory can be detected.
  logic [PcWidth:0]   pc_q, pc_d;
  logic [15:0]        instr_q, instr_d;
  logic [15:0]        result_q, result_d;
  logic [7:0]         count_q, count_d;
  logic [TmWidth-1:0] timer_q, timer_d;
  logic               imm_q, imm_d;
  logic               finished_q, finished_d;
  logic               error_q, error_d;

  logic               in_range;
  logic [15:0]        cur_word;
  logic [PcWidth:0]   pc_adv;
  logic [TmWidth-1:0] timer_inc;
  logic               idle_like;
  logic               mem_we;

  assign in_range  = (pc_q <= LastPc);
  assign cur_word  = in_range ? mem[pc_q[PcWidth-1:0]] : 16'h0000;
  assign pc_adv    = pc_q + {{PcWidth{1'b0}}, imm_q};
  assign timer_inc = timer_q + 1'b1;
  assign idle_like = (state_q == StIdle) || (state_q == StHalt) || (state_q == StError);
  assign mem_we    = LoadEn && idle_like;

  // Program memory keeps its contents through reset.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      instr_q    <= '0;
      result_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      imm_q      <= 1'b0;
      finished_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      result_q   <= result_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      imm_q      <= imm_d;
      finished_q <= finished_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    result_d   = result_q;
    count_d    = count_q;
    timer_d    = timer_q;
    imm_d      = imm_q;
    finished_d = finished_q;
    error_d    = error_q;
    case (state_q)
      StIdle, StHalt, StError: begin
        if (Start) begin
          state_d    = StIssue;
          pc_d       = '0;
          count_d    = '0;
          timer_d    = '0;
          imm_d      = 1'b0;
          finished_d = 1'b0;
          error_d    = 1'b0;
        end
      end
      StIssue: begin
        if (!in_range || cur_word == HALT_WORD) begin
          state_d    = StHalt;
          finished_d = 1'b1;
        end else begin
          state_d = StWait;
          instr_d = cur_word;
          imm_d   = (cur_word[8:6] == 3'b111);
          pc_d    = pc_q + 1'b1;
          timer_d = '0;
        end
      end
      StWait: begin
        if (Done) begin
          result_d = BusWires;
          count_d  = count_q + 8'd1;
          imm_d    = 1'b0;
          pc_d     = pc_adv;
          if (pc_adv > LastPc) begin
            state_d    = StHalt;
            finished_d = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TimeoutVal) begin
            state_d = StError;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Run  = 1'b0;
    DIN  = 16'h0000;
    Busy = 1'b0;
    case (state_q)
      StIssue: begin
        Busy = 1'b1;
        if (in_range && cur_word != HALT_WORD) begin
          Run = 1'b1;
          DIN = cur_word;
        end
      end
      // An mvi leaves the immediate word at the current address on DIN.
      StWait: begin
        Busy = 1'b1;
        DIN  = imm_q ? cur_word : instr_q;
      end
      default: ;
    endcase
  end

  assign PC         = pc_q[PcWidth-1:0];
  assign Result     = result_q;
  assign InstrCount = count_q;
  assign Finished   = finished_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: random programs against a queue-based reference walk of the memory,
// with a monitor that scores every issued word and the held WAIT word.
`timescale 1ns / 1ps

module tb_instr_feeder;

  localparam int unsigned DEPTH = 32;
  localparam logic [15:0] HALT  = 16'hFFFF;

  logic        Clock = 1'b0, Resetn = 1'b1, Start = 1'b0, LoadEn = 1'b0, Done = 1'b0;
  logic [4:0]  LoadAddr = '0;
  logic [15:0] LoadData = '0, BusWires = '0;
  logic [15:0] DIN, Result;
  logic        Run, Busy, Finished, Error;
  logic [4:0]  PC;
  logic [7:0]  InstrCount;

  instr_feeder #(.DEPTH(32), .TIMEOUT(15), .HALT_WORD(16'hFFFF)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .Done(Done), .BusWires(BusWires), .DIN(DIN), .Run(Run), .PC(PC),
    .Result(Result), .InstrCount(InstrCount), .Busy(Busy), .Finished(Finished), .Error(Error)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {logic [15:0] din; logic [15:0] wdin;} exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] ref_mem [DEPTH];
  int          vectors = 0, miscompares = 0, runs = 0;
  logic [15:0] last_bus = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Reference: walk the program word by word; an mvi consumes the following word as data.
  function automatic void model(output int n, output int end_pc);
    int pc;
    logic [15:0] w;
    exp_t e;
    pc = 0;
    n  = 0;
    while (pc < DEPTH && ref_mem[pc] != HALT) begin
      w      = ref_mem[pc];
      e.din  = w;
      if (w[8:6] == 3'b111) begin
        e.wdin = (pc + 1 < DEPTH) ? ref_mem[pc + 1] : 16'h0000;
        pc += 2;
      end else begin
        e.wdin = w;
        pc += 1;
      end
      exp_q.push_back(e);
      n++;
    end
    end_pc = pc;
  endfunction

  // Monitor: every Run pops one expectation; every later WAIT cycle must hold the same DIN.
  bit          in_wait = 1'b0;
  int          wait_age = 0;
  logic [15:0] wait_din = '0;

  always @(negedge Clock) begin
    if (!Resetn) begin
      in_wait = 1'b0;
    end else begin
      if (in_wait && (!Busy || (wait_age > 0 && Done))) in_wait = 1'b0;
      if (Run) begin
        runs++;
        check("run_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("issue_din", DIN, mon_e.din);
          in_wait  = 1'b1;
          wait_age = 0;
          wait_din = mon_e.wdin;
        end
      end else if (in_wait) begin
        check("wait_din_held", DIN, wait_din);
        wait_age++;
      end
    end
  end

  task automatic load_word(input int a, input logic [15:0] d);
    @(negedge Clock);
    #1 LoadEn = 1'b1; LoadAddr = 5'(a); LoadData = d; ref_mem[a] = d;
    @(negedge Clock);
    #1 LoadEn = 1'b0;
  endtask

  // dly < 0 picks a random Done delay per instruction; inject adds Start/LoadEn/Done noise.
  task automatic run_prog(input bit inject, input int dly, input string tag, output int n);
    int  end_pc, budget, d;
    bit  r, b;
    exp_q.delete();
    model(n, end_pc);
    runs = 0;
    @(negedge Clock);
    #1 Start = 1'b1;
    @(negedge Clock);
    budget = 4000;
    while (budget > 0) begin
      r = Run;
      b = Busy;
      #1 Done = 1'b0; Start = 1'b0; LoadEn = 1'b0;
      if (!b) break;
      if (r) begin
        if (inject && $urandom_range(0, 1) == 1) begin
          Done = 1'b1; Start = 1'b1; LoadEn = 1'b1;
          LoadAddr = 5'($urandom); LoadData = 16'($urandom);
        end
        @(negedge Clock);
        #1 Done = 1'b0; Start = 1'b0; LoadEn = 1'b0;
        if (inject) begin
          Start = 1'b1; LoadEn = 1'b1; LoadAddr = 5'($urandom); LoadData = 16'($urandom);
        end
        d = (dly < 0) ? $urandom_range(0, 3) : dly;
        repeat (d) begin
          @(negedge Clock);
          #1 Start = 1'b0; LoadEn = 1'b0;
        end
        BusWires = 16'($urandom);
        last_bus = BusWires;
        Done     = 1'b1;
      end
      @(negedge Clock);
      budget--;
    end
    check({tag, "_in_budget"}, 32'(budget > 0), 1);
    check({tag, "_runs"}, runs, n);
    check({tag, "_count"}, InstrCount, n);
    check({tag, "_finished"}, Finished, 1);
    check({tag, "_error"}, Error, 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    if (n > 0) check({tag, "_result"}, Result, last_bus);
    if (end_pc < DEPTH) check({tag, "_pc"}, PC, end_pc);
  endtask

  initial begin
    int n;
    logic [15:0] w, prev_result;
    exp_t e;
    int busy_seen, runs_snap;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #3 Resetn = 1'b0;
    #1;
    check("rst_din", DIN, 0);
    check("rst_run", Run, 0);
    check("rst_pc", PC, 0);
    check("rst_result", Result, 0);
    check("rst_count", InstrCount, 0);
    check("rst_busy", Busy, 0);
    check("rst_finished", Finished, 0);
    check("rst_error", Error, 0);
    @(negedge Clock);
    #1 Resetn = 1'b1;

    // Single instruction then halt, Done three cycles after Run.
    load_word(0, 16'h0008);
    load_word(1, HALT);
    run_prog(1'b0, 2, "single", n);

    // mvi with immediate, then halt.
    load_word(0, 16'h01C0);
    load_word(1, 16'h00AB);
    load_word(2, HALT);
    run_prog(1'b0, -1, "mvi", n);

    // Whole memory of plain instructions: run off the end.
    for (int i = 0; i < DEPTH; i++) begin
      w = 16'($urandom);
      w[6] = 1'b0;
      load_word(i, w);
    end
    run_prog(1'b0, -1, "full", n);

    // Random programs with Start/LoadEn/Done noise while busy.
    for (int p = 0; p < 15; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 4) == 0) w[8:6] = 3'b111;
        if (i == DEPTH - 1 && w[8:6] == 3'b111) w[6] = 1'b0;
        if (w == HALT) w = '0;
        load_word(i, w);
      end
      begin
        int h;
        h = $urandom_range(0, 34);
        if (h < DEPTH) load_word(h, HALT);
      end
      run_prog(1'b1, -1, "rand", n);
      #1 Done = 1'b1;
      @(negedge Clock);
      #1 Done = 1'b0;
      @(negedge Clock);
      check("idle_done_ignored", InstrCount, n);
    end

    // Done never arrives.
    load_word(0, 16'h0048);
    load_word(1, HALT);
    prev_result = Result;
    exp_q.delete();
    model(n, busy_seen);
    e = exp_q[0];
    exp_q.delete();
    exp_q.push_back(e);
    @(negedge Clock);
    #1 Start = 1'b1;
    @(negedge Clock);
    check("hang_issue_run", Run, 1);
    #1 Start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clock);
      if (k == 15) check("hang_error_early", Error, 0);
    end
    check("hang_error", Error, 1);
    check("hang_busy", Busy, 0);
    check("hang_pc_frozen", PC, 1);
    check("hang_result_frozen", Result, prev_result);
    runs_snap = runs;
    repeat (5) @(negedge Clock);
    check("hang_no_more_runs", runs, runs_snap);
    exp_q.push_back(e);
    #1 Start = 1'b1;
    @(negedge Clock);
    check("restart_pc", PC, 0);
    check("restart_error", Error, 0);
    check("restart_busy", Busy, 1);
    #1 Start = 1'b0;
    repeat (20) @(negedge Clock);
    check("rehang_error", Error, 1);
    check("rehang_queue", exp_q.size(), 0);

    // Reset mid-WAIT, then rerun the retained program.
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      w[6] = 1'b0;
      if (w == HALT) w = '0;
      load_word(i, w);
    end
    load_word(8, HALT);
    exp_q.delete();
    model(n, busy_seen);
    @(negedge Clock);
    #1 Start = 1'b1;
    @(negedge Clock);
    #1 Start = 1'b0;
    @(negedge Clock);
    #1 Done = 1'b1; BusWires = 16'h5A5A;
    @(negedge Clock);
    #1 Done = 1'b0;
    @(negedge Clock);
    check("pre_reset_busy", Busy, 1);
    #2 Resetn = 1'b0;
    #1;
    check("mid_rst_din", DIN, 0);
    check("mid_rst_run", Run, 0);
    check("mid_rst_pc", PC, 0);
    check("mid_rst_result", Result, 0);
    check("mid_rst_count", InstrCount, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_finished", Finished, 0);
    check("mid_rst_error", Error, 0);
    @(negedge Clock);
    #1 Resetn = 1'b1;
    busy_seen = 0;
    repeat (6) begin
      @(negedge Clock);
      if (Busy || Run) busy_seen++;
    end
    check("idle_after_reset", busy_seen, 0);
    run_prog(1'b0, -1, "rerun", n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
